// File: rtl/reaction_game.sv
// reaction_game: one-button reaction-time game.
// A cooldown is followed by a pseudo-random wait. The ready LED then lights,
// and the player's reaction time is shown as a 0-3 LED thermometer score.
// A press during the wait is a false start, shown by blinking all score LEDs.
// Ports:
//   clk          in   system clock; all logic runs on the rising edge
//   rst_n        in   asynchronous active-low reset
//   button       in   raw push button, active-high, asynchronous to clk
//   cooldownLed  out  high during COOLDOWN
//   rdyLed       out  high during READY
//   led0..led2   out  score thermometer, or false-start blink
//
// state     | meaning
// ----------+-----------------------------------------------------------
// COOLDOWN  | cooldownLed on, presses ignored, latches random wait on exit
// WAIT      | all LEDs off, a press here is a false start
// READY     | rdyLed on, the timer measures the reaction time
// RESULT    | shows the latched score
// FALSE     | false start, led0..2 blink together
module reaction_game #(
    parameter int unsigned TICK_CYCLES  = 12000,
    parameter int unsigned DEBOUNCE_CYC = 60000,
    parameter int unsigned COOLDOWN_MS  = 1000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11,
    parameter int unsigned FAST_MS      = 200,
    parameter int unsigned MID_MS       = 300,
    parameter int unsigned SLOW_MS      = 500,
    parameter int unsigned TIMEOUT_MS   = 1000,
    parameter int unsigned RESULT_MS    = 2000,
    parameter int unsigned FALSE_MS     = 2000,
    parameter int unsigned BLINK_MS     = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic cooldownLed,
    output logic rdyLed,
    output logic led0,
    output logic led1,
    output logic led2
);

    localparam logic [2:0] ST_COOLDOWN = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_READY    = 3'd2;
    localparam logic [2:0] ST_RESULT   = 3'd3;
    localparam logic [2:0] ST_FALSE    = 3'd4;

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DEB_RELOAD = DW'(DEBOUNCE_CYC - 1);

    localparam logic [15:0] COOLDOWN_T  = 16'(COOLDOWN_MS);
    localparam logic [15:0] MIN_DELAY_T = 16'(MIN_DELAY_MS);
    localparam logic [15:0] FAST_T      = 16'(FAST_MS);
    localparam logic [15:0] MID_T       = 16'(MID_MS);
    localparam logic [15:0] SLOW_T      = 16'(SLOW_MS);
    localparam logic [15:0] TIMEOUT_T   = 16'(TIMEOUT_MS);
    localparam logic [15:0] RESULT_T    = 16'(RESULT_MS);
    localparam logic [15:0] FALSE_T     = 16'(FALSE_MS);
    localparam logic [15:0] BLINK_LAST  = 16'(BLINK_MS - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_prev_q;
    logic [DW-1:0] deb_cnt_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   lfsr_q;
    logic [2:0]    state_q, state_d;
    logic [15:0]   timer_q, timer_inc;
    logic [15:0]   delay_q, delay_d;
    logic [2:0]    score_q, score_d;
    logic          blink_q;
    logic [15:0]   blink_cnt_q;
    logic          cooldown_led_q, rdy_led_q;
    logic [2:0]    led_q;
    logic          tick, press, lfsr_fb, state_change;

    assign tick         = (presc_q == TICK_LAST);
    // Edge-detected, so a button held across a state change is never a press.
    assign press        = deb_q & ~deb_prev_q;
    assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign timer_inc    = timer_q + 16'd1;
    assign state_change = (state_d != state_q);

    // Debounced level follows the synced button only after DEBOUNCE_CYC
    // consecutive samples that differ from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= DEB_RELOAD;
        end else begin
            sync1_q    <= button;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= DEB_RELOAD;
            end else if (deb_cnt_q == '0) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= DEB_RELOAD;
            end else begin
                deb_cnt_q <= deb_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            lfsr_q  <= 16'hACE1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // Timed exits compare against timer_inc so they fire on the tick that
    // makes the timer equal to the limit.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        score_d = score_q;
        case (state_q)
            ST_COOLDOWN: begin
                if (tick && timer_inc == COOLDOWN_T) begin
                    state_d = ST_WAIT;
                    delay_d = MIN_DELAY_T + 16'(lfsr_q[RAND_BITS-1:0]);
                end
            end
            ST_WAIT: begin
                if (press) begin
                    state_d = ST_FALSE;
                end else if (tick && timer_inc == delay_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (press) begin
                    state_d = ST_RESULT;
                    if (timer_q < FAST_T) begin
                        score_d = 3'b111;
                    end else if (timer_q < MID_T) begin
                        score_d = 3'b011;
                    end else if (timer_q < SLOW_T) begin
                        score_d = 3'b001;
                    end else begin
                        score_d = 3'b000;
                    end
                end else if (tick && timer_inc == TIMEOUT_T) begin
                    state_d = ST_RESULT;
                    score_d = 3'b000;
                end
            end
            ST_RESULT: begin
                if (tick && timer_inc == RESULT_T) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_FALSE: begin
                if (tick && timer_inc == FALSE_T) begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: begin
                state_d = ST_COOLDOWN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COOLDOWN;
            timer_q     <= '0;
            delay_q     <= '0;
            score_q     <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            score_q <= score_d;
            if (state_change) begin
                timer_q     <= '0;
                blink_q     <= 1'b1;
                blink_cnt_q <= BLINK_LAST;
            end else if (tick) begin
                timer_q <= timer_inc;
                if (blink_cnt_q == '0) begin
                    blink_q     <= ~blink_q;
                    blink_cnt_q <= BLINK_LAST;
                end else begin
                    blink_cnt_q <= blink_cnt_q - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_led_q <= 1'b0;
            rdy_led_q      <= 1'b0;
            led_q          <= '0;
        end else begin
            cooldown_led_q <= (state_q == ST_COOLDOWN);
            rdy_led_q      <= (state_q == ST_READY);
            if (state_q == ST_RESULT) begin
                led_q <= score_q;
            end else if (state_q == ST_FALSE) begin
                led_q <= {3{blink_q}};
            end else begin
                led_q <= '0;
            end
        end
    end

    assign cooldownLed = cooldown_led_q;
    assign rdyLed      = rdy_led_q;
    assign led0        = led_q[0];
    assign led1        = led_q[1];
    assign led2        = led_q[2];

endmodule

// File: tb/tb_reaction_game.sv
module tb_reaction_game;

    localparam int TICK  = 10;
    localparam int DEB   = 4;
    localparam int COOL  = 20;
    localparam int MIND  = 20;
    localparam int RB    = 5;
    localparam int FAST  = 20;
    localparam int MID   = 30;
    localparam int SLOW  = 50;
    localparam int TMO   = 100;
    localparam int RES   = 40;
    localparam int FLS   = 40;
    localparam int BLINK = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button = 1'b0;
    logic cooldownLed, rdyLed, led0, led1, led2;

    int n_pass = 0;
    int n_checks = 0;
    int exp_wait;

    reaction_game #(
        .TICK_CYCLES(TICK), .DEBOUNCE_CYC(DEB), .COOLDOWN_MS(COOL),
        .MIN_DELAY_MS(MIND), .RAND_BITS(RB), .FAST_MS(FAST), .MID_MS(MID),
        .SLOW_MS(SLOW), .TIMEOUT_MS(TMO), .RESULT_MS(RES), .FALSE_MS(FLS),
        .BLINK_MS(BLINK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button),
        .cooldownLed(cooldownLed), .rdyLed(rdyLed),
        .led0(led0), .led1(led1), .led2(led2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cooldownLed;
            1:       return rdyLed;
            default: return led0 | led1 | led2;
        endcase
    endfunction

    function automatic int leds();
        return int'({led2, led1, led0});
    endfunction

    function automatic int all_out();
        return int'({cooldownLed, rdyLed, led2, led1, led0});
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n = samples taken before the signal reached val; n == limit on expiry
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            if (sig(sel) == val) return;
            n++;
        end
    endtask

    // Press p ms after READY entry; rdyLed is seen one cycle after entry.
    task automatic play(input string tag, input int p, input bit glitch, input int exp);
        int n;
        int used;
        used = 0;
        wait_sig(1, 1'b1, 1000, n);
        check_val({tag, "_rdy_seen"}, int'(n < 1000), 1);
        if (glitch) begin
            cycles(30); button = 1'b1; cycles(2); button = 1'b0;
            cycles(28); button = 1'b1; cycles(2); button = 1'b0;
            check_val({tag, "_glitch_rdy"}, int'(rdyLed), 1);
            used = 62;
        end
        cycles(10 * p - 1 - used);
        button = 1'b1;
        wait_sig(1, 1'b0, 100, n);
        check_val({tag, "_press_latency"}, int'(n < 20), 1);
        cycles(3);
        check_val({tag, "_score"}, leds(), exp);
        button = 1'b0;
        wait_sig(0, 1'b1, 1000, n);
        check_val({tag, "_back_to_cooldown"}, int'(n > 300 && n < 420), 1);
    endtask

    initial begin
        int n;
        logic [15:0] l;
        l = 16'hACE1;
        repeat (199) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        exp_wait = 10 * (MIND + int'(l[RB-1:0])) - 1;

        cycles(3);
        check_val("reset_outputs", all_out(), 0);
        rst_n = 1'b1;

        // idle round: timeout gives score 0
        wait_sig(0, 1'b0, 1000, n);
        check_val("cooldown_len", n, 10 * COOL);
        wait_sig(1, 1'b1, 1000, n);
        check_val("wait_len", n, exp_wait);
        wait_sig(1, 1'b0, 2000, n);
        check_val("timeout_len", n, 10 * TMO - 1);
        check_val("timeout_score", leds(), 0);
        wait_sig(0, 1'b1, 1000, n);
        check_val("result_len", n, 10 * RES - 1);

        play("rt15", 15, 1'b0, 7);
        play("rt25", 25, 1'b1, 3);
        play("rt40", 40, 1'b0, 1);
        play("rt70", 70, 1'b0, 0);

        // false start
        wait_sig(0, 1'b0, 1000, n);
        cycles(50);
        button = 1'b1;
        wait_sig(2, 1'b1, 50, n);
        check_val("false_on", leds(), 7);
        check_val("false_rdy_off", int'(rdyLed), 0);
        button = 1'b0;
        cycles(140);
        check_val("false_blink_off", leds(), 0);
        check_val("false_rdy_still_off", int'(rdyLed), 0);
        cycles(100);
        check_val("false_blink_on", leds(), 7);
        wait_sig(0, 1'b1, 600, n);
        check_val("false_to_cooldown", int'(n > 100 && n < 200), 1);

        // button held from COOLDOWN through WAIT into READY
        button = 1'b1;
        wait_sig(0, 1'b0, 1000, n);
        wait_sig(1, 1'b1, 700, n);
        check_val("hold_reaches_ready", int'(n < 700), 1);
        check_val("hold_no_false", leds(), 0);
        cycles(50);
        check_val("hold_no_score", int'(rdyLed), 1);
        button = 1'b0;
        cycles(20);
        button = 1'b1;
        wait_sig(1, 1'b0, 100, n);
        check_val("hold_repress_latency", int'(n < 20), 1);
        cycles(3);
        check_val("hold_repress_score", leds(), 7);
        button = 1'b0;
        wait_sig(0, 1'b1, 1000, n);

        // reset during READY
        wait_sig(1, 1'b1, 1000, n);
        cycles(100);
        rst_n = 1'b0;
        #1;
        check_val("midgame_reset_outputs", all_out(), 0);
        cycles(3);
        rst_n = 1'b1;
        wait_sig(0, 1'b0, 1000, n);
        check_val("reset_cooldown_len", n, 10 * COOL);
        wait_sig(1, 1'b1, 1000, n);
        check_val("reset_same_wait", n, exp_wait);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
